// File: rtl/srt_rem_fixup.sv
// srt_rem_fixup: final remainder/quotient correction stage of an SRT divider
// Takes the last partial remainder, the normalised divisor and the converted
// quotient. When the remainder is negative it adds the divisor back and
// decrements the quotient. Otherwise it passes both through unchanged.
// Ports: clk, rst (async, active-high); in_valid/in_ready with in_rem/in_div/in_quo;
//        out_valid/out_ready with out_rem/out_quo/out_fix/out_sticky.
// Build option: SRT_FIXUP_STICKY_EN enables out_sticky = (corrected remainder != 0).
// When the option is off, out_sticky is tied low.
module srt_rem_fixup #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rem,
  input  logic [WIDTH-1:0] in_div,
  input  logic [WIDTH-1:0] in_quo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rem,
  output logic [WIDTH-1:0] out_quo,
  output logic             out_fix,
  output logic             out_sticky
);
  typedef enum logic [1:0] {IDLE, CHECK, CORRECT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] rem_q, div_q, quo_q, sum;
  assign sum = rem_q + div_q;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef SRT_FIXUP_STICKY_EN
  logic sticky_q;
  assign out_sticky = sticky_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= 1'b0;
    else if (state == CHECK && !rem_q[WIDTH-1]) sticky_q <= |rem_q;
    else if (state == CORRECT) sticky_q <= |sum;
`else
  assign out_sticky = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      out_rem <= '0;
      out_quo <= '0;
      out_fix <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem_q <= in_rem;
          div_q <= in_div;
          quo_q <= in_quo;
          state <= CHECK;
        end
        CHECK: if (rem_q[WIDTH-1]) state <= CORRECT;
        else begin
          out_rem <= rem_q;
          out_quo <= quo_q;
          out_fix <= 1'b0;
          state <= DONE;
        end
        CORRECT: begin
          out_rem <= sum;
          out_quo <= quo_q - WIDTH'(1);
          out_fix <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_srt_rem_fixup.sv
// tb_srt_rem_fixup: scoreboard bench for srt_rem_fixup with directed vectors
module tb_srt_rem_fixup;
  localparam int W = 26;
`ifdef SRT_FIXUP_STICKY_EN
  localparam logic ST = 1'b1;
`else
  localparam logic ST = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_fix, out_sticky;
  logic [W-1:0] in_rem = '0, in_div = '0, in_quo = '0, out_rem, out_quo;
  typedef struct {
    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic fix;
    logic sticky;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, nchk = 0, nfail = 0, seen = 0;
  srt_rem_fixup #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rem(in_rem), .in_div(in_div), .in_quo(in_quo),
    .out_valid(out_valid), .out_ready(out_ready), .out_rem(out_rem),
    .out_quo(out_quo), .out_fix(out_fix), .out_sticky(out_sticky)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  logic pv = 0, pr = 0, pf = 0, ps = 0;
  logic [W-1:0] prem = '0, pquo = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !pv) begin
        seen++;
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
        else chk("unexpected_valid", 1, 0);
      end
      if (out_valid && pv && !pr) begin
        chk("hold_rem", out_rem, prem);
        chk("hold_quo", out_quo, pquo);
        chk("hold_fix", out_fix, pf);
        chk("hold_sticky", out_sticky, ps);
        chk("hold_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rem", out_rem, e.rem);
        chk("quo", out_quo, e.quo);
        chk("fix", out_fix, e.fix);
        chk("sticky", out_sticky, e.sticky);
      end
    end
    pv = out_valid; pr = out_ready; prem = out_rem; pquo = out_quo; pf = out_fix; ps = out_sticky;
  end
  task automatic send(input logic [W-1:0] r, d, q, er, eq, input logic ef, es, input int el);
    int t = 0;
    in_rem = r; in_div = d; in_quo = q; in_valid = 1;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else sb.push_back('{er, eq, ef, es, el, cyc});
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rem", out_rem, 0);
    chk("rst_out_quo", out_quo, 0);
    chk("rst_out_fix", out_fix, 0);
    chk("rst_out_sticky", out_sticky, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    send(26'd5, 26'd12, 26'd3, 26'd5, 26'd3, 0, ST, 2);
    drain();
    @(negedge clk);
    send(26'h3FFFFF9, 26'd12, 26'd4, 26'd5, 26'd3, 1, ST, 3);
    drain();
    @(negedge clk);
    send(26'h3FFFFF4, 26'd12, 26'd0, 26'd0, 26'h3FFFFFF, 1, 0, 3);
    drain();
    @(negedge clk);
    send(26'd0, 26'd12, 26'd7, 26'd0, 26'd7, 0, 0, 2);
    drain();
    @(negedge clk);
    send(26'h1FFFFFF, 26'd12, 26'h2000000, 26'h1FFFFFF, 26'h2000000, 0, ST, 2);
    drain();
    @(negedge clk);
    send(26'h2000000, 26'h1FFFFFF, 26'd5, 26'h3FFFFFF, 26'd4, 1, ST, 3);
    drain();
    @(negedge clk);
    out_ready = 0;
    send(26'h3FFFFFF, 26'd1, 26'd0, 26'd0, 26'h3FFFFFF, 1, 0, 3);
    repeat (3) @(negedge clk);
    chk("done_reached", out_valid, 1);
    in_rem = 26'd77; in_div = 26'd99; in_quo = 26'd55; in_valid = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 0;
    send(26'd100, 26'd200, 26'd9, 26'd100, 26'd9, 0, ST, 2);
    @(negedge clk);
    out_ready = 1;
    send(26'd40, 26'd50, 26'd6, 26'd40, 26'd6, 0, ST, 2);
    drain();
    @(negedge clk);
    send(26'h3FFFFF9, 26'd12, 26'd4, 26'd5, 26'd3, 1, ST, 3);
    @(posedge clk);
    #2 rst = 1;
    #1;
    sb.delete();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_rem", out_rem, 0);
    chk("mid_rst_out_quo", out_quo, 0);
    chk("mid_rst_out_fix", out_fix, 0);
    chk("mid_rst_out_sticky", out_sticky, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (8) @(negedge clk);
    chk("no_valid_after_rst", seen, 0);
    chk("post_rst_in_ready", in_ready, 1);
    send(26'd9, 26'd12, 26'd1, 26'd9, 26'd1, 0, ST, 2);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
